vxe_mem_req_arb: RTL and testbench

Two-client round-robin arbiter for the VxE memory request path. It merges the address (rqa) and write-data (rqd) request streams of two memory clients into the single rqa/rqd channel that feeds the AXI switch upstream unit. Write data beats leave in the same order as their write addresses. One output register stage per channel.

---
 rtl/vxe_mem_req_arb.sv | 110 +++++++++++
 tb/tb_vxe_mem_req_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vxe_mem_req_arb.sv
// Two-client round-robin merge of the VxE rqa/rqd memory request streams.
// Optional VXE_MEM_ARB_TAG_EN: o_m_rqa[43] carries the granted client index.
module vxe_mem_req_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_c0_rqa_vld,
    input  logic [43:0] i_c0_rqa,
    output logic        o_c0_rqa_rd,
    input  logic        i_c1_rqa_vld,
    input  logic [43:0] i_c1_rqa,
    output logic        o_c1_rqa_rd,
    input  logic        i_c0_rqd_vld,
    input  logic [71:0] i_c0_rqd,
    output logic        o_c0_rqd_rd,
    input  logic        i_c1_rqd_vld,
    input  logic [71:0] i_c1_rqd,
    output logic        o_c1_rqd_rd,
    output logic        o_m_rqa_vld,
    output logic [43:0] o_m_rqa,
    input  logic        i_m_rqa_rd,
    output logic        o_m_rqd_vld,
    output logic [71:0] o_m_rqd,
    input  logic        i_m_rqd_rd
);

    typedef enum logic {ARB, WDATA} state_t;

    state_t      state, state_nx;
    logic        last, last_nx;
    logic        owner, owner_nx;
    logic        ora_free, ord_free;
    logic        gnt0, gnt1, ld_a, ld_d;
    logic [43:0] rqa_sel;
    logic [71:0] rqd_sel;

    always_comb begin
        state_nx = state;
        last_nx  = last;
        owner_nx = owner;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        ld_a     = 1'b0;
        ld_d     = 1'b0;
        ora_free = !o_m_rqa_vld || i_m_rqa_rd;
        ord_free = !o_m_rqd_vld || i_m_rqd_rd;
        unique case (state)
            ARB: begin
                if (ora_free) begin
                    gnt1 = i_c1_rqa_vld && (!i_c0_rqa_vld || !last);
                    gnt0 = i_c0_rqa_vld && !gnt1;
                end
            end
            WDATA: begin
                if (ord_free && (owner ? i_c1_rqd_vld : i_c0_rqd_vld)) begin
                    ld_d     = 1'b1;
                    state_nx = ARB;
                end
            end
            default: state_nx = ARB;
        endcase
        rqa_sel = gnt1 ? i_c1_rqa : i_c0_rqa;
`ifdef VXE_MEM_ARB_TAG_EN
        rqa_sel[43] = gnt1;
`endif
        rqd_sel = owner ? i_c1_rqd : i_c0_rqd;
        if (gnt0 || gnt1) begin
            ld_a    = 1'b1;
            last_nx = gnt1;
            if (!rqa_sel[37]) begin
                owner_nx = gnt1;
                state_nx = WDATA;
            end
        end
    end

    // Pops are held off while reset is asserted so clients see no stray pulses.
    assign o_c0_rqa_rd = gnt0 && !rst;
    assign o_c1_rqa_rd = gnt1 && !rst;
    assign o_c0_rqd_rd = ld_d && !owner && !rst;
    assign o_c1_rqd_rd = ld_d && owner && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB;
            last        <= 1'b1;
            owner       <= 1'b0;
            o_m_rqa_vld <= 1'b0;
            o_m_rqa     <= '0;
            o_m_rqd_vld <= 1'b0;
            o_m_rqd     <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            owner <= owner_nx;
            if (ld_a) begin
                o_m_rqa_vld <= 1'b1;
                o_m_rqa     <= rqa_sel;
            end else if (i_m_rqa_rd) begin
                o_m_rqa_vld <= 1'b0;
            end
            if (ld_d) begin
                o_m_rqd_vld <= 1'b1;
                o_m_rqd     <= rqd_sel;
            end else if (i_m_rqd_rd) begin
                o_m_rqd_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vxe_mem_req_arb.sv
// Directed testbench for vxe_mem_req_arb with queue-backed client models.
// Define VXE_MEM_ARB_TAG_EN for both bench and RTL to cover the tag build.
module tb_vxe_mem_req_arb;

    logic        clk;
    logic        rst;
    logic        i_c0_rqa_vld, i_c1_rqa_vld, i_c0_rqd_vld, i_c1_rqd_vld;
    logic [43:0] i_c0_rqa, i_c1_rqa;
    logic [71:0] i_c0_rqd, i_c1_rqd;
    logic        o_c0_rqa_rd, o_c1_rqa_rd, o_c0_rqd_rd, o_c1_rqd_rd;
    logic        o_m_rqa_vld, o_m_rqd_vld;
    logic [43:0] o_m_rqa;
    logic [71:0] o_m_rqd;
    logic        i_m_rqa_rd, i_m_rqd_rd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [43:0] c0a[$];
    logic [43:0] c1a[$];
    logic [71:0] c0d[$];
    logic [71:0] c1d[$];
    bit p0a, p1a, p0d, p1d;

    vxe_mem_req_arb dut (
        .clk(clk), .rst(rst),
        .i_c0_rqa_vld(i_c0_rqa_vld), .i_c0_rqa(i_c0_rqa), .o_c0_rqa_rd(o_c0_rqa_rd),
        .i_c1_rqa_vld(i_c1_rqa_vld), .i_c1_rqa(i_c1_rqa), .o_c1_rqa_rd(o_c1_rqa_rd),
        .i_c0_rqd_vld(i_c0_rqd_vld), .i_c0_rqd(i_c0_rqd), .o_c0_rqd_rd(o_c0_rqd_rd),
        .i_c1_rqd_vld(i_c1_rqd_vld), .i_c1_rqd(i_c1_rqd), .o_c1_rqd_rd(o_c1_rqd_rd),
        .o_m_rqa_vld(o_m_rqa_vld), .o_m_rqa(o_m_rqa), .i_m_rqa_rd(i_m_rqa_rd),
        .o_m_rqd_vld(o_m_rqd_vld), .o_m_rqd(o_m_rqd), .i_m_rqd_rd(i_m_rqd_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [43:0] exp_rqa(input logic [43:0] r, input logic c);
        logic [43:0] e;
        e = r;
`ifdef VXE_MEM_ARB_TAG_EN
        e[43] = c;
`else
        if (c) e = r;
`endif
        return e;
    endfunction

    // One clock: latch pops seen this cycle, retire them, present next heads.
    task automatic tick();
        logic [43:0] ta;
        logic [71:0] td;
        p0a = o_c0_rqa_rd;
        p1a = o_c1_rqa_rd;
        p0d = o_c0_rqd_rd;
        p1d = o_c1_rqd_rd;
        @(negedge clk);
        if (p0a && c0a.size() > 0) ta = c0a.pop_front();
        if (p1a && c1a.size() > 0) ta = c1a.pop_front();
        if (p0d && c0d.size() > 0) td = c0d.pop_front();
        if (p1d && c1d.size() > 0) td = c1d.pop_front();
        i_c0_rqa_vld = c0a.size() != 0;
        i_c0_rqa     = (c0a.size() != 0) ? c0a[0] : '0;
        i_c1_rqa_vld = c1a.size() != 0;
        i_c1_rqa     = (c1a.size() != 0) ? c1a[0] : '0;
        i_c0_rqd_vld = c0d.size() != 0;
        i_c0_rqd     = (c0d.size() != 0) ? c0d[0] : '0;
        i_c1_rqd_vld = c1d.size() != 0;
        i_c1_rqd     = (c1d.size() != 0) ? c1d[0] : '0;
        #2;
    endtask

    task automatic flush();
        c0a.delete();
        c1a.delete();
        c0d.delete();
        c1d.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        tick();
        tick();
        rst = 1'b0;
        i_m_rqa_rd = 1'b1;
        i_m_rqd_rd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        c0a.push_back({6'h01, 1'b1, 37'h4});
        tick();
        n_cmp++;
        if (o_m_rqa_vld !== 1'b0 || o_m_rqd_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vld got %b/%b want 0/0", o_m_rqa_vld, o_m_rqd_vld);
        end
        n_cmp++;
        if (o_m_rqa !== 44'h0 || o_m_rqd !== 72'h0) begin
            n_bad++;
            $display("FAIL reset_data got %h/%h want 0/0", o_m_rqa, o_m_rqd);
        end
        n_cmp++;
        if ({o_c0_rqa_rd, o_c1_rqa_rd, o_c0_rqd_rd, o_c1_rqd_rd} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_rd got %b want 0000",
                     {o_c0_rqa_rd, o_c1_rqa_rd, o_c0_rqd_rd, o_c1_rqd_rd});
        end
        flush();
    endtask

    task automatic test_single_read();
        logic [43:0] r;
        do_reset();
        r = {6'h05, 1'b1, 37'h10};
        c0a.push_back(r);
        tick();
        n_cmp++;
        if (o_c0_rqa_rd !== 1'b1 || o_m_rqa_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL single_c1 got rd=%b vld=%b want 1/0", o_c0_rqa_rd, o_m_rqa_vld);
        end
        tick();
        n_cmp++;
        if (o_m_rqa_vld !== 1'b1 || o_m_rqa !== r) begin
            n_bad++;
            $display("FAIL single_c2 got vld=%b %h want 1 %h", o_m_rqa_vld, o_m_rqa, r);
        end
        n_cmp++;
        if (o_c0_rqa_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL single_nopop got %b want 0", o_c0_rqa_rd);
        end
        tick();
        n_cmp++;
        if (o_m_rqa_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drain got %b want 0", o_m_rqa_vld);
        end
    endtask

    task automatic test_fairness();
        logic [43:0] e0[4];
        logic [43:0] e1[4];
        logic [43:0] ex;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            e0[i] = {6'(i), 1'b1, 37'(i * 8)};
            e1[i] = {6'(8 + i), 1'b1, 37'(256 + i)};
            c0a.push_back(e0[i]);
            c1a.push_back(e1[i]);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k <= 8) begin
                n_cmp++;
                if (o_c0_rqa_rd !== 1'(k % 2) || o_c1_rqa_rd !== 1'(1 - k % 2)) begin
                    n_bad++;
                    $display("FAIL fair_grant k=%0d got %b%b want %b%b", k,
                             o_c0_rqa_rd, o_c1_rqa_rd, 1'(k % 2), 1'(1 - k % 2));
                end
            end
            if (k >= 2) begin
                ex = ((k - 2) % 2 == 0) ? exp_rqa(e0[(k - 2) / 2], 1'b0)
                                        : exp_rqa(e1[(k - 2) / 2], 1'b1);
                n_cmp++;
                if (o_m_rqa_vld !== 1'b1 || o_m_rqa !== ex) begin
                    n_bad++;
                    $display("FAIL fair_out k=%0d got %b %h want 1 %h", k,
                             o_m_rqa_vld, o_m_rqa, ex);
                end
            end
        end
    endtask

    task automatic test_write_order();
        logic [43:0] w;
        logic [43:0] r;
        logic [71:0] d;
        do_reset();
        w = {6'h07, 1'b0, 37'h20};
        r = {6'h02, 1'b1, 37'h30};
        d = {8'hFF, 64'hA5A5_A5A5_A5A5_A5A5};
        c1a.push_back(w);
        c0d.push_back({8'h0F, 64'h1234});
        tick();
        n_cmp++;
        if (o_c1_rqa_rd !== 1'b1 || o_c0_rqd_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_grant got c1a=%b c0d=%b want 1/0", o_c1_rqa_rd, o_c0_rqd_rd);
        end
        c0a.push_back(r);
        tick();
        n_cmp++;
        if (o_m_rqa_vld !== 1'b1 || o_m_rqa !== exp_rqa(w, 1'b1)) begin
            n_bad++;
            $display("FAIL wr_addr got %b %h want 1 %h", o_m_rqa_vld, o_m_rqa,
                     exp_rqa(w, 1'b1));
        end
        n_cmp++;
        if ({o_c0_rqa_rd, o_c0_rqd_rd, o_c1_rqd_rd} !== 3'b000) begin
            n_bad++;
            $display("FAIL wr_hold got %b want 000", {o_c0_rqa_rd, o_c0_rqd_rd, o_c1_rqd_rd});
        end
        c1d.push_back(d);
        tick();
        n_cmp++;
        if ({o_c0_rqa_rd, o_c0_rqd_rd, o_c1_rqd_rd} !== 3'b001) begin
            n_bad++;
            $display("FAIL wr_data_pop got %b want 001",
                     {o_c0_rqa_rd, o_c0_rqd_rd, o_c1_rqd_rd});
        end
        tick();
        n_cmp++;
        if (o_m_rqd_vld !== 1'b1 || o_m_rqd !== d) begin
            n_bad++;
            $display("FAIL wr_data got %b %h want 1 %h", o_m_rqd_vld, o_m_rqd, d);
        end
        n_cmp++;
        if (o_c0_rqa_rd !== 1'b1 || o_c0_rqd_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_resume got c0a=%b c0d=%b want 1/0", o_c0_rqa_rd, o_c0_rqd_rd);
        end
    endtask

    task automatic test_backpressure();
        logic [43:0] a;
        logic [43:0] b;
        int pops;
        do_reset();
        a = {6'h09, 1'b1, 37'h40};
        b = {6'h0A, 1'b1, 37'h48};
        i_m_rqa_rd = 1'b0;
        c0a.push_back(a);
        c0a.push_back(b);
        pops = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (o_c0_rqa_rd) pops++;
            if (k >= 2) begin
                n_cmp++;
                if (o_m_rqa_vld !== 1'b1 || o_m_rqa !== exp_rqa(a, 1'b0)) begin
                    n_bad++;
                    $display("FAIL bp_hold k=%0d got %b %h want 1 %h", k,
                             o_m_rqa_vld, o_m_rqa, exp_rqa(a, 1'b0));
                end
            end
        end
        n_cmp++;
        if (pops != 1) begin
            n_bad++;
            $display("FAIL bp_pops got %0d want 1", pops);
        end
        i_m_rqa_rd = 1'b1;
        #1;
        n_cmp++;
        if (o_c0_rqa_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release got %b want 1", o_c0_rqa_rd);
        end
        tick();
        n_cmp++;
        if (o_m_rqa_vld !== 1'b1 || o_m_rqa !== exp_rqa(b, 1'b0)) begin
            n_bad++;
            $display("FAIL bp_reload got %b %h want 1 %h", o_m_rqa_vld, o_m_rqa,
                     exp_rqa(b, 1'b0));
        end
    endtask

    task automatic test_reset_wdata();
        do_reset();
        c0a.push_back({6'h0B, 1'b0, 37'h50});
        c1a.push_back({6'h0C, 1'b1, 37'h58});
        tick();
        n_cmp++;
        if (o_c0_rqa_rd !== 1'b1 || o_c1_rqa_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL rw_grant got %b%b want 10", o_c0_rqa_rd, o_c1_rqa_rd);
        end
        tick();
        n_cmp++;
        if (o_m_rqa_vld !== 1'b1 || o_c1_rqa_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL rw_wdata got vld=%b c1a=%b want 1/0", o_m_rqa_vld, o_c1_rqa_rd);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_m_rqa_vld, o_m_rqd_vld, o_c0_rqa_rd, o_c1_rqa_rd,
             o_c0_rqd_rd, o_c1_rqd_rd} !== 6'b0) begin
            n_bad++;
            $display("FAIL rw_async got %b want 000000",
                     {o_m_rqa_vld, o_m_rqd_vld, o_c0_rqa_rd, o_c1_rqa_rd,
                      o_c0_rqd_rd, o_c1_rqd_rd});
        end
        flush();
        tick();
        c0a.push_back({6'h0D, 1'b1, 37'h60});
        c1a.push_back({6'h0E, 1'b1, 37'h68});
        rst = 1'b0;
        tick();
        n_cmp++;
        if (o_c0_rqa_rd !== 1'b1 || o_c1_rqa_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL rw_first got %b%b want 10", o_c0_rqa_rd, o_c1_rqa_rd);
        end
    endtask

    task automatic test_tag();
        logic [5:0] want;
        do_reset();
`ifdef VXE_MEM_ARB_TAG_EN
        want = 6'h23;
`else
        want = 6'h03;
`endif
        c1a.push_back({6'h03, 1'b1, 37'h70});
        tick();
        tick();
        n_cmp++;
        if (o_m_rqa_vld !== 1'b1 || o_m_rqa[43:38] !== want) begin
            n_bad++;
            $display("FAIL tag got %b %h want 1 %h", o_m_rqa_vld, o_m_rqa[43:38], want);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_m_rqa_rd = 1'b1;
        i_m_rqd_rd = 1'b1;
        i_c0_rqa_vld = 1'b0; i_c0_rqa = '0;
        i_c1_rqa_vld = 1'b0; i_c1_rqa = '0;
        i_c0_rqd_vld = 1'b0; i_c0_rqd = '0;
        i_c1_rqd_vld = 1'b0; i_c1_rqd = '0;
        test_reset();
        test_single_read();
        test_fairness();
        test_write_order();
        test_backpressure();
        test_reset_wdata();
        test_tag();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
